snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Parametrised game-flow controller for the snake game, successor to the fixed prepare/start/end controller.
//  Sits beside the datapath: takes user/game events and drives state flags, snake size, lives, score and speed level.
//  Adds pause, multiple lives, a win condition, score and level tracking.
//  Edge-detects every event input internally, so the datapath may hold events high for any number of cycles.
// PARAMETERS
//  SIZE_W      5   width of size output
//  INIT_SIZE   3   snake length after reset, restart or respawn
//  MAX_SIZE    31  length at which the game is won; must satisfy INIT_SIZE < MAX_SIZE <= 2**SIZE_W-1
//  GROW        1   segments added per cherry
//  LIVES       3   lives at game start, 1..7
//  SCORE_W     10  width of score counter
//  LEVEL_STEP  4   cherries per level increment
//  MAX_LEVEL   7   level saturation value, <= 7
// PORTS
//  clk             in   1        system clock (100 MHz)
//  reset           in   1        synchronous, active-high
//  userStart       in   1        start/resume request, level
//  userPause       in   1        pause toggle request, level
//  snakeEatCherry  in   1        cherry eaten, level
//  bump            in   1        collision, level
//  restart         in   1        new-game request, level
//  gamePrepare     out  1        state == PREPARE
//  gameStart       out  1        state == PLAY
//  gamePaused      out  1        state == PAUSE
//  gameEnd         out  1        state == END
//  gameWin         out  1        state == WIN
//  size            out  SIZE_W   current snake length
//  lives           out  3        remaining lives
//  score           out  SCORE_W  cherries eaten this game, saturating
//  level           out  3        speed level, 0..MAX_LEVEL
// BEHAVIOUR
//  - Event detection: each input is registered once; a rise is prev==0 && cur==1. An input held high acts once.
//    The rise is consumed in the cycle after the input edge, so outputs change 2 clk after the input rises.
//  - Reset (sync, clk edge with reset=1):
//    state=PREPARE, size=INIT_SIZE, lives=LIVES, score=0, level=0, all edge registers cleared.
//  - Output flags are registered and one-hot with state.
//  - State machine (only the transitions listed exist):
//    PREPARE --userStart rise--> PLAY
//    PLAY --userPause rise--> PAUSE;  PAUSE --userPause or userStart rise--> PLAY
//    PLAY --bump rise, lives>1--> PREPARE: lives-=1, size=INIT_SIZE; score and level kept
//    PLAY --bump rise, lives==1--> END: lives=0
//    PLAY --cherry rise, size+GROW>=MAX_SIZE--> WIN: size=MAX_SIZE
//    PLAY --cherry rise, otherwise--> PLAY: size+=GROW
//    END/WIN --restart rise--> PREPARE: full reset values
//  - Every cherry rise in PLAY: score+=1, saturating at 2**SCORE_W-1.
//    An internal count cnt_lvl counts up; when it reaches LEVEL_STEP, cnt_lvl=0 and level+=1, saturating at MAX_LEVEL.
//  - Priority within PLAY on the same cycle: bump > cherry > userPause. Lower-priority rises are discarded, not queued.
//  - restart rise in PREPARE/PLAY/PAUSE is ignored. Cherry and bump rises outside PLAY are ignored.
//  - Reset mid-game: reset wins over every event in the same cycle.
// TESTING
//  1. reset, then userStart held 10 cycles -> PREPARE->PLAY exactly once; size=3, lives=3, score=0.
//  2. In PLAY: 4 cherry pulses -> size=7, score=4, level=1; cherry held 20 cycles -> counts as one (size 8).
//  3. In PLAY: bump -> PREPARE, lives=2, size=3, score kept.
//     Repeat until the third bump -> END, lives=0, gameEnd=1.
//     Then restart -> PREPARE with lives=3, score=0, level=0.
//  4. In PLAY: pause rise -> gamePaused=1; cherry/bump while paused -> no change; userStart -> PLAY.
//  5. Bump and cherry rise on the same cycle (lives=3, size=5) -> PREPARE, lives=2, size=3, score unchanged.
//  6. MAX_SIZE=8, in PLAY: 5 cherries -> WIN, size=8; further cherries ignored; restart -> PREPARE, size=3.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game flow controller: state, size, lives, score, level.
// All event inputs are rise-detected, so the datapath may hold them high.
module snake_game_ctrl #(
  parameter int SIZE_W     = 5,
  parameter int INIT_SIZE  = 3,
  parameter int MAX_SIZE   = 31,
  parameter int GROW       = 1,
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 10,
  parameter int LEVEL_STEP = 4,
  parameter int MAX_LEVEL  = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               userStart,
  input  logic               userPause,
  input  logic               snakeEatCherry,
  input  logic               bump,
  input  logic               restart,
  output logic               gamePrepare,
  output logic               gameStart,
  output logic               gamePaused,
  output logic               gameEnd,
  output logic               gameWin,
  output logic [SIZE_W-1:0]  size,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         level
);

  localparam int CNT_W = $clog2(LEVEL_STEP + 1);

  typedef enum logic [2:0] {S_PREPARE, S_PLAY, S_PAUSE, S_END, S_WIN} state_t;

  state_t             state, state_n;
  logic [4:0]         cur_q, prev_q, rise;
  logic [SIZE_W-1:0]  size_n;
  logic [SIZE_W:0]    grown;
  logic [2:0]         lives_n, level_n;
  logic [SCORE_W-1:0] score_n;
  logic [CNT_W-1:0]   cnt_lvl, cnt_n;

  // bit order: restart, bump, cherry, pause, start
  assign rise  = cur_q & ~prev_q;
  assign grown = {1'b0, size} + (SIZE_W+1)'(GROW);

  always_comb begin
    state_n = state;
    size_n  = size;
    lives_n = lives;
    score_n = score;
    level_n = level;
    cnt_n   = cnt_lvl;
    case (state)
      S_PREPARE: if (rise[0]) state_n = S_PLAY;
      S_PLAY: begin
        if (rise[3]) begin
          if (lives > 3'd1) begin
            state_n = S_PREPARE;
            lives_n = lives - 3'd1;
            size_n  = SIZE_W'(INIT_SIZE);
          end else begin
            state_n = S_END;
            lives_n = 3'd0;
          end
        end else if (rise[2]) begin
          if (score != {SCORE_W{1'b1}}) score_n = score + 1'b1;
          if (cnt_lvl == CNT_W'(LEVEL_STEP - 1)) begin
            cnt_n = '0;
            if (level < 3'(MAX_LEVEL)) level_n = level + 3'd1;
          end else begin
            cnt_n = cnt_lvl + 1'b1;
          end
          if (grown >= (SIZE_W+1)'(MAX_SIZE)) begin
            state_n = S_WIN;
            size_n  = SIZE_W'(MAX_SIZE);
          end else begin
            size_n = grown[SIZE_W-1:0];
          end
        end else if (rise[1]) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: if (rise[1] || rise[0]) state_n = S_PLAY;
      S_END, S_WIN: begin
        if (rise[4]) begin
          state_n = S_PREPARE;
          size_n  = SIZE_W'(INIT_SIZE);
          lives_n = 3'(LIVES);
          score_n = '0;
          level_n = 3'd0;
          cnt_n   = '0;
        end
      end
      default: state_n = S_PREPARE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PREPARE;
      size        <= SIZE_W'(INIT_SIZE);
      lives       <= 3'(LIVES);
      score       <= '0;
      level       <= 3'd0;
      cnt_lvl     <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      gamePrepare <= 1'b1;
      gameStart   <= 1'b0;
      gamePaused  <= 1'b0;
      gameEnd     <= 1'b0;
      gameWin     <= 1'b0;
    end else begin
      state       <= state_n;
      size        <= size_n;
      lives       <= lives_n;
      score       <= score_n;
      level       <= level_n;
      cnt_lvl     <= cnt_n;
      cur_q       <= {restart, bump, snakeEatCherry, userPause, userStart};
      prev_q      <= cur_q;
      // flags follow the next state so they stay one-hot with state
      gamePrepare <= (state_n == S_PREPARE);
      gameStart   <= (state_n == S_PLAY);
      gamePaused  <= (state_n == S_PAUSE);
      gameEnd     <= (state_n == S_END);
      gameWin     <= (state_n == S_WIN);
    end
  end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - scoreboard bench for snake_game_ctrl (MAX_SIZE=8, SCORE_W=3).
module tb_snake_game_ctrl;

  localparam logic [4:0] FP = 5'b10000, FS = 5'b01000, FA = 5'b00100, FE = 5'b00010, FW = 5'b00001;
  localparam logic [4:0] E_START = 5'b00001, E_PAUSE = 5'b00010, E_CHERRY = 5'b00100,
                         E_BUMP = 5'b01000, E_RESTART = 5'b10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] drive = 5'b0;
  logic       gamePrepare, gameStart, gamePaused, gameEnd, gameWin;
  logic [4:0] size;
  logic [2:0] lives, score, level;

  typedef struct {
    logic [18:0] v;
    string       name;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic        chk = 1'b0;
  logic [18:0] last;

  always #5 clk = ~clk;

  snake_game_ctrl #(.MAX_SIZE(8), .SCORE_W(3)) dut (
    .clk(clk), .reset(reset),
    .userStart(drive[0]), .userPause(drive[1]), .snakeEatCherry(drive[2]),
    .bump(drive[3]), .restart(drive[4]),
    .gamePrepare(gamePrepare), .gameStart(gameStart), .gamePaused(gamePaused),
    .gameEnd(gameEnd), .gameWin(gameWin),
    .size(size), .lives(lives), .score(score), .level(level)
  );

  function automatic logic [18:0] mk(input logic [4:0] f, input int sz, input int lv,
                                     input int sc, input int lev);
    return {f, 5'(sz), 3'(lv), 3'(sc), 3'(lev)};
  endfunction

  // monitor: pops one expectation per observed output change or checkpoint strobe
  always @(negedge clk) begin
    if (mon_en) begin
      logic [18:0] cur;
      cur = {gamePrepare, gameStart, gamePaused, gameEnd, gameWin, size, lives, score, level};
      if (cur !== last || chk) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change got=%h required=no change", cur);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (cur !== e.v) begin
            n_fail++;
            $display("FAIL %s got flags=%b size=%0d lives=%0d score=%0d level=%0d required flags=%b size=%0d lives=%0d score=%0d level=%0d",
                     e.name, cur[18:14], cur[13:9], cur[8:6], cur[5:3], cur[2:0],
                     e.v[18:14], e.v[13:9], e.v[8:6], e.v[5:3], e.v[2:0]);
          end
        end
      end
      last = cur;
    end
  end

  task automatic expect_out(input string name, input logic [4:0] f, input int sz,
                            input int lv, input int sc, input int lev);
    exp_t e;
    e.v = mk(f, sz, lv, sc, lev);
    e.name = name;
    q.push_back(e);
  endtask

  task automatic checkpoint(input string name, input logic [4:0] f, input int sz,
                            input int lv, input int sc, input int lev);
    expect_out(name, f, sz, lv, sc, lev);
    @(posedge clk); #1 chk = 1'b1;
    @(posedge clk); #1 chk = 1'b0;
  endtask

  task automatic ev(input logic [4:0] v, input int hold);
    @(posedge clk); #1 drive = v;
    repeat (hold) @(posedge clk);
    #1 drive = 5'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    expect_out("reset_state", FP, 3, 3, 0, 0);
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    expect_out("start_held", FS, 3, 3, 0, 0);      ev(E_START, 10);
    expect_out("cherry1", FS, 4, 3, 1, 0);          ev(E_CHERRY, 1);
    expect_out("cherry2", FS, 5, 3, 2, 0);          ev(E_CHERRY, 1);
    expect_out("cherry3", FS, 6, 3, 3, 0);          ev(E_CHERRY, 1);
    expect_out("cherry4_level", FS, 7, 3, 4, 1);    ev(E_CHERRY, 1);
    expect_out("cherry_held_win", FW, 8, 3, 5, 1);  ev(E_CHERRY, 20);
    ev(E_CHERRY, 1); ev(E_BUMP, 1); ev(E_START, 1); ev(E_PAUSE, 1);
    checkpoint("win_ignores", FW, 8, 3, 5, 1);
    expect_out("restart_from_win", FP, 3, 3, 0, 0); ev(E_RESTART, 1);

    expect_out("start2", FS, 3, 3, 0, 0);           ev(E_START, 1);
    expect_out("pause", FA, 3, 3, 0, 0);            ev(E_PAUSE, 1);
    ev(E_CHERRY, 1); ev(E_BUMP, 1); ev(E_RESTART, 1);
    checkpoint("pause_ignores", FA, 3, 3, 0, 0);
    expect_out("resume_start", FS, 3, 3, 0, 0);     ev(E_START, 1);
    expect_out("pause2", FA, 3, 3, 0, 0);           ev(E_PAUSE, 1);
    expect_out("resume_pause", FS, 3, 3, 0, 0);     ev(E_PAUSE, 1);

    expect_out("c_a", FS, 4, 3, 1, 0);              ev(E_CHERRY, 1);
    expect_out("c_b", FS, 5, 3, 2, 0);              ev(E_CHERRY, 1);
    expect_out("bump_over_cherry", FP, 3, 2, 2, 0); ev(E_BUMP | E_CHERRY, 1);
    expect_out("start3", FS, 3, 2, 2, 0);           ev(E_START, 1);
    expect_out("c_c", FS, 4, 2, 3, 0);              ev(E_CHERRY, 1);
    expect_out("c_d_level", FS, 5, 2, 4, 1);        ev(E_CHERRY, 1);
    expect_out("c_e", FS, 6, 2, 5, 1);              ev(E_CHERRY, 1);
    expect_out("bump_life2", FP, 3, 1, 5, 1);       ev(E_BUMP, 1);
    expect_out("start4", FS, 3, 1, 5, 1);           ev(E_START, 1);
    expect_out("c_f", FS, 4, 1, 6, 1);              ev(E_CHERRY, 1);
    expect_out("c_g_score_max", FS, 5, 1, 7, 1);    ev(E_CHERRY, 1);
    expect_out("c_h_score_sat", FS, 6, 1, 7, 2);    ev(E_CHERRY, 1);
    expect_out("cherry_over_pause", FS, 7, 1, 7, 2); ev(E_CHERRY | E_PAUSE, 1);
    expect_out("last_bump_end", FE, 7, 0, 7, 2);    ev(E_BUMP, 1);
    ev(E_CHERRY, 1); ev(E_START, 1); ev(E_PAUSE, 1);
    checkpoint("end_ignores", FE, 7, 0, 7, 2);
    expect_out("restart_from_end", FP, 3, 3, 0, 0); ev(E_RESTART, 1);

    expect_out("start5", FS, 3, 3, 0, 0);           ev(E_START, 1);
    expect_out("c_i", FS, 4, 3, 1, 0);              ev(E_CHERRY, 1);
    // reset lands on the cycle the cherry rise would be consumed
    expect_out("reset_wins", FP, 3, 3, 0, 0);
    @(posedge clk); #1 drive = E_CHERRY;
    @(posedge clk); #1 reset = 1'b1; drive = 5'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    ev(E_PAUSE, 1);
    checkpoint("prepare_ignores_pause", FP, 3, 3, 0, 0);

    repeat (5) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expectations got=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
